// File: rtl/lights_pkg.sv
// lights_pkg: shared constants and types for the lights-off input path and game core
package lights_pkg;

    localparam int NUM_SW       = 10;
    localparam int DEF_TICK_DIV = 50000;
    localparam int DEF_DB_TICKS = 10;

    typedef logic [NUM_SW-1:0] sw_vec_t;

endpackage

// File: rtl/lights_debounce.sv
// lights_debounce: 2-flop synchroniser plus tick-based debouncer for one raw input
module lights_debounce
    import lights_pkg::*;
#(
    parameter int DB_TICKS = DEF_DB_TICKS,
    parameter bit INVERT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int            CW       = $clog2(DB_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;
    logic          in_lvl;
    logic          accept;

    // two-flop synchroniser; an inverted (active-low) input idles released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= INVERT;
            s2_q <= INVERT;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    assign in_lvl = s2_q ^ INVERT;
    assign accept = (in_lvl != db_q) && tick_i && (cnt_q == CNT_LAST);

    // any return to the accepted level restarts the count; inverted channels only pulse on press
    always_comb begin
        db_d    = accept ? in_lvl : db_q;
        cnt_d   = (in_lvl == db_q || accept) ? '0 : (tick_i ? cnt_q + 1'b1 : cnt_q);
        pulse_d = accept && (!INVERT || in_lvl);
    end

    // debounce state and registered edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q    <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_o = db_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/lights_input_conditioner.sv
// lights_input_conditioner: debounced switches/buttons with toggle pulses and pending mask
// Build option LIGHTS_INPUT_PEND_EN: registered sticky sw_pend cleared by pend_clr;
// otherwise sw_pend mirrors sw_toggle and pend_clr is ignored.
module lights_input_conditioner
    import lights_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DB_TICKS = DEF_DB_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw,
    input  logic              btn_fix,
    input  logic              btn_rand,
    input  logic              pend_clr,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_toggle,
    output logic [NUM_SW-1:0] sw_pend,
    output logic              fix_press,
    output logic              rand_press
);

    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [1:0]    btn_level_unused;

    assign tick = tick_cnt_q == TW'(TICK_DIV - 1);

    // free-running divider producing one tick every TICK_DIV cycles
    always_comb tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt_q <= '0;
        else        tick_cnt_q <= tick_cnt_d;
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        lights_debounce #(.DB_TICKS(DB_TICKS), .INVERT(1'b0)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (sw[i]),
            .tick_i  (tick),
            .level_o (sw_level[i]),
            .pulse_o (sw_toggle[i])
        );
    end

    lights_debounce #(.DB_TICKS(DB_TICKS), .INVERT(1'b1)) u_fix (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (btn_fix),
        .tick_i  (tick),
        .level_o (btn_level_unused[0]),
        .pulse_o (fix_press)
    );

    lights_debounce #(.DB_TICKS(DB_TICKS), .INVERT(1'b1)) u_rand (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (btn_rand),
        .tick_i  (tick),
        .level_o (btn_level_unused[1]),
        .pulse_o (rand_press)
    );

`ifdef LIGHTS_INPUT_PEND_EN
    logic [NUM_SW-1:0] pend_q, pend_d;

    // sticky toggle capture; a toggle arriving with the clear survives it
    always_comb pend_d = (pend_q & ~{NUM_SW{pend_clr}}) | sw_toggle;

    // pending mask register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign sw_pend = pend_q;
`else
    logic pend_clr_unused;

    assign pend_clr_unused = pend_clr;
    assign sw_pend         = sw_toggle;
`endif

endmodule

// File: doc/lights_input_conditioner.md
# lights_input_conditioner

Input conditioning stage that sits directly upstream of the lights-off game core. It synchronises and debounces the 10 raw slide switches and the 2 raw active-low push buttons (`btn_fix`, `btn_rand`), then emits clean levels, single-cycle toggle/press pulses and a sticky per-switch pending mask. The game core consumes the pending mask and clears it with a strobe, replacing its ad-hoc free-running-counter sampling.

## Interface
Parameters:
- `TICK_DIV`, 50000: `clk` cycles per debounce tick (1 ms at 50 MHz); legal values ≥ 2.
- `DB_TICKS`, 10: consecutive ticks an input must differ from its debounced state before the change is accepted; legal values ≥ 1.

Ports (one clock; reset is asynchronous and active-low, `rst_n`):
- `clk`, input, 1: 50 MHz system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `sw`, input, 10: raw switches, asynchronous to `clk`.
- `btn_fix`, input, 1: raw button, active-low, asynchronous.
- `btn_rand`, input, 1: raw button, active-low, asynchronous.
- `pend_clr`, input, 1: one-cycle strobe from the game core that clears `sw_pend`.
- `sw_level`, output, 10: debounced switch levels.
- `sw_toggle`, output, 10: one-cycle pulse per bit on an accepted change of that switch.
- `sw_pend`, output, 10: sticky OR of `sw_toggle` since the last `pend_clr`.
- `fix_press`, output, 1: one-cycle pulse on an accepted press of `btn_fix`.
- `rand_press`, output, 1: one-cycle pulse on an accepted press of `btn_rand`.

## Operation
- **Synchroniser:** each of the 12 raw inputs passes through 2 flops. Switch synchroniser flops reset to 0. Button synchroniser flops reset to 1 (released).
- **Tick generator:** `tick_cnt` counts from 0 to `TICK_DIV-1` and wraps. `tick` is high for the single cycle in which `tick_cnt == TICK_DIV-1`. `tick_cnt` resets to 0.
- **Per-channel debouncer:**
  - State is `db` (accepted level) and `cnt` (width `$clog2(DB_TICKS+1)`).
  - Any cycle with `sync == db`: `cnt <= 0`.
  - Cycle with `sync != db` and `tick`:
    - If `cnt == DB_TICKS-1`: `db <= sync`, `cnt <= 0`, and the edge pulse is asserted.
    - Otherwise: `cnt <= cnt+1`.
  - Cycle with `sync != db` and no `tick`: hold `cnt`.
  - A bounce back to `db` at any cycle restarts the count. `cnt` never exceeds `DB_TICKS-1`.
- **Switch channels:** `sw_level = db`. `sw_toggle` pulses on every accepted change, in both directions.
- **Button channels:** `db` holds the inverted sync level (1 = pressed). `fix_press`/`rand_press` pulse only on an accepted 0→1 change of the pressed flag. Release produces no pulse.
- **Pending mask:** `sw_pend <= (sw_pend & ~{10{pend_clr}}) | sw_toggle`. If `pend_clr` and `sw_toggle[i]` occur in the same cycle, the new toggle wins and bit i stays set.
- **Reset values:** `sw_level = 0`, `sw_toggle = 0`, `sw_pend = 0`, `fix_press = 0`, `rand_press = 0`, all `cnt = 0`, all `db = 0`.
- **Reset mid-operation:** all state returns to its reset value immediately. No pulse is emitted on reset assertion or release.
- **Simultaneous events:** channels are fully independent. Any combination of pulses may coincide in one cycle.

## Timing
- All outputs are registered. Each pulse is high for exactly 1 `clk` cycle, in the same cycle its `sw_level` bit changes.
- Latency from a raw edge held stable to the accepted change:
  - Minimum: 2 + (`DB_TICKS-1`)·`TICK_DIV` + 1 cycles.
  - Maximum: 2 + `DB_TICKS`·`TICK_DIV` cycles.
- `sw_pend` reflects a toggle one cycle after the `sw_toggle` pulse. `pend_clr` takes effect on the next edge.
- Minimum spacing between two pulses on one channel is `DB_TICKS` ticks.

## Configuration
- `LIGHTS_INPUT_PEND_EN` defined: the `sw_pend` register and `pend_clr` logic are built as described above.
- Not defined: `sw_pend` is driven combinationally from `sw_toggle`, and `pend_clr` is ignored. The port list is unchanged.

## Structure
- Shared package `lights_pkg` holds:
  - `NUM_SW = 10`
  - `DEF_TICK_DIV = 50000`
  - `DEF_DB_TICKS = 10`
  - typedef `sw_vec_t` (logic [NUM_SW-1:0]), also used by the game core.
- One sub-module, `lights_debounce`: 2-flop synchroniser, `db`/`cnt`, and an edge output. It takes the shared `tick` and an `INVERT` parameter for the buttons. It is instantiated 12 times.
- The tick generator and pending mask live in the top module.

## Test plan
Bench parameters: `TICK_DIV = 4`, `DB_TICKS = 3`, with `LIGHTS_INPUT_PEND_EN` defined unless stated otherwise.

1. Reset then idle: `sw = 0`, buttons = 1 for 100 cycles → all outputs stay 0 and no pulses occur.
2. Clean switch edge: `sw[3]` 0→1 and held → exactly one `sw_toggle[3]` pulse within 11–14 cycles, `sw_level[3] = 1`, `sw_pend = 10'h008`.
3. Bounce: `sw[5]` toggles every 5 cycles for 40 cycles, then stays 1 → no pulse during the bounce, then one pulse 11–14 cycles after it settles.
4. Button press and release: `btn_fix` low for 40 cycles, then high → one `fix_press` pulse, no pulse on release, and `rand_press` stays 0.
5. Clear collision: `pend_clr` in the same cycle as a `sw_toggle[0]` pulse, with `sw_pend = 10'h201` beforehand → `sw_pend = 10'h001` afterwards. Build without `LIGHTS_INPUT_PEND_EN` → `sw_pend` equals `sw_toggle` every cycle.
6. Reset mid-count: `sw[9]` = 1 held for 2 ticks, assert `rst_n` low for 1 cycle, keep `sw[9]` high → the full debounce latency restarts from reset release, with one pulse and no extra pulse.
